// File: rtl/encoder_decoder_unit.sv
// encoder_decoder_unit
//
// Registered coding stage with three independent functions sharing one clock:
//   - one-hot to binary encoder (with error flag for non-one-hot inputs)
//   - priority encoder (highest-numbered set bit wins)
//   - binary to one-hot decoder (with enable)
// Each function samples its inputs every cycle; results appear one clock later.
//
// Ports:
//   clk          rising-edge clock for all output registers
//   rst_n        asynchronous active-low reset; clears every output
//   enc_in       [N-1:0]     one-hot vector to encode
//   enc_out      [SEL_W-1:0] index of the set bit of enc_in (0 on error)
//   enc_err      enc_in was not exactly one-hot
//   p_enc_in     [N-1:0]     request vector for the priority encoder
//   p_enc_out    [SEL_W-1:0] index of the most-significant set bit (0 if none)
//   p_enc_valid  at least one bit of p_enc_in was set
//   dec_in       [SEL_W-1:0] binary index to decode
//   dec_en       decoder enable
//   dec_out      [N-1:0]     one-hot decode of dec_in, or zero when disabled
module encoder_decoder_unit #(
  parameter int unsigned SEL_W = 2,
  localparam int unsigned N    = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     enc_in,
  output logic [SEL_W-1:0] enc_out,
  output logic             enc_err,
  input  logic [N-1:0]     p_enc_in,
  output logic [SEL_W-1:0] p_enc_out,
  output logic             p_enc_valid,
  input  logic [SEL_W-1:0] dec_in,
  input  logic             dec_en,
  output logic [N-1:0]     dec_out
);

  logic [SEL_W-1:0] enc_out_d;
  logic             enc_err_d;
  logic [SEL_W-1:0] p_enc_out_d;
  logic             p_enc_valid_d;
  logic [N-1:0]     dec_out_d;

  logic [SEL_W-1:0] enc_idx;
  int unsigned      enc_cnt;

  // Plain encoder: count set bits while remembering the index of the last one.
  always_comb begin
    enc_idx = '0;
    enc_cnt = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (enc_in[i]) begin
        enc_cnt = enc_cnt + 1;
        enc_idx = SEL_W'(i);
      end
    end
    if (enc_cnt == 1) begin
      enc_out_d = enc_idx;
      enc_err_d = 1'b0;
    end else begin
      enc_out_d = '0;
      enc_err_d = 1'b1;
    end
  end

  // Priority encoder: ascending scan, so the highest set bit is the last write.
  always_comb begin
    p_enc_out_d   = '0;
    p_enc_valid_d = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (p_enc_in[i]) begin
        p_enc_out_d   = SEL_W'(i);
        p_enc_valid_d = 1'b1;
      end
    end
  end

  // Decoder.
  always_comb begin
    dec_out_d = '0;
    if (dec_en) begin
      dec_out_d = N'(1) << dec_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_out     <= '0;
      enc_err     <= 1'b0;
      p_enc_out   <= '0;
      p_enc_valid <= 1'b0;
      dec_out     <= '0;
    end else begin
      enc_out     <= enc_out_d;
      enc_err     <= enc_err_d;
      p_enc_out   <= p_enc_out_d;
      p_enc_valid <= p_enc_valid_d;
      dec_out     <= dec_out_d;
    end
  end

endmodule

// File: tb/tb_encoder_decoder_unit.sv
module tb_encoder_decoder_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] enc_in;
  logic [1:0] enc_out;
  logic       enc_err;
  logic [3:0] p_enc_in;
  logic [1:0] p_enc_out;
  logic       p_enc_valid;
  logic [1:0] dec_in;
  logic       dec_en;
  logic [3:0] dec_out;

  encoder_decoder_unit #(.SEL_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enc_in      (enc_in),
    .enc_out     (enc_out),
    .enc_err     (enc_err),
    .p_enc_in    (p_enc_in),
    .p_enc_out   (p_enc_out),
    .p_enc_valid (p_enc_valid),
    .dec_in      (dec_in),
    .dec_en      (dec_en),
    .dec_out     (dec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0] enc_in;
    logic [3:0] p_enc_in;
    logic [1:0] dec_in;
    logic       dec_en;
    logic [1:0] exp_enc_out;
    logic       exp_enc_err;
    logic [1:0] exp_p_out;
    logic       exp_p_valid;
    logic [3:0] exp_dec_out;
  } vec_t;

  vec_t vecs[16];

  // Reference model, computed from arithmetic on the input values.
  function automatic void model(input int e, input int p, input int d, input bit en,
                                output int eo, output int ee, output int po, output int pv,
                                output int dq);
    if ($countones(e) == 1) begin eo = $clog2(e); ee = 0; end
    else begin eo = 0; ee = 1; end
    if (p == 0) begin po = 0; pv = 0; end
    else begin po = $clog2(p + 1) - 1; pv = 1; end
    dq = en ? (1 << d) : 0;
  endfunction

  task automatic check_all(input string tag, input int eo, input int ee, input int po,
                           input int pv, input int dq);
    check({tag, ".enc_out"},     32'(enc_out),     32'(eo));
    check({tag, ".enc_err"},     32'(enc_err),     32'(ee));
    check({tag, ".p_enc_out"},   32'(p_enc_out),   32'(po));
    check({tag, ".p_enc_valid"}, 32'(p_enc_valid), 32'(pv));
    check({tag, ".dec_out"},     32'(dec_out),     32'(dq));
  endtask

  initial begin
    // Encoder and priority sweeps 0..15, decoder pattern interleaved to show independence.
    vecs[0]  = '{4'd0,  4'd0,  2'd0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 4'b0001};
    vecs[1]  = '{4'd1,  4'd1,  2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 4'b0010};
    vecs[2]  = '{4'd2,  4'd2,  2'd2, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 4'b0100};
    vecs[3]  = '{4'd3,  4'd3,  2'd3, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 4'b1000};
    vecs[4]  = '{4'd4,  4'd4,  2'd2, 1'b0, 2'd2, 1'b0, 2'd2, 1'b1, 4'b0000};
    vecs[5]  = '{4'd5,  4'd5,  2'd1, 1'b1, 2'd0, 1'b1, 2'd2, 1'b1, 4'b0010};
    vecs[6]  = '{4'd6,  4'd6,  2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 4'b0000};
    vecs[7]  = '{4'd7,  4'd7,  2'd3, 1'b1, 2'd0, 1'b1, 2'd2, 1'b1, 4'b1000};
    vecs[8]  = '{4'd8,  4'd8,  2'd0, 1'b1, 2'd3, 1'b0, 2'd3, 1'b1, 4'b0001};
    vecs[9]  = '{4'd9,  4'd9,  2'd2, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 4'b0100};
    vecs[10] = '{4'd10, 4'd10, 2'd3, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 4'b0000};
    vecs[11] = '{4'd11, 4'd11, 2'd1, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 4'b0010};
    vecs[12] = '{4'd12, 4'd12, 2'd0, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 4'b0001};
    vecs[13] = '{4'd13, 4'd13, 2'd3, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 4'b1000};
    vecs[14] = '{4'd14, 4'd14, 2'd2, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 4'b0100};
    vecs[15] = '{4'd15, 4'd15, 2'd1, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 4'b0000};

    rst_n    = 1'b0;
    enc_in   = 4'b0100;
    p_enc_in = 4'b1000;
    dec_in   = 2'd3;
    dec_en   = 1'b1;

    // Reset holds outputs at zero across edges.
    #3;
    check_all("reset_t0", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_all("reset_hold", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sweep; inputs change every cycle back to back.
    for (int i = 0; i < 16; i++) begin
      enc_in   = vecs[i].enc_in;
      p_enc_in = vecs[i].p_enc_in;
      dec_in   = vecs[i].dec_in;
      dec_en   = vecs[i].dec_en;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_enc_out), int'(vecs[i].exp_enc_err),
                int'(vecs[i].exp_p_out), int'(vecs[i].exp_p_valid), int'(vecs[i].exp_dec_out));
    end

    // Spot check 0110 priority, then asynchronous reset mid-cycle.
    enc_in   = 4'b0100;
    p_enc_in = 4'b0110;
    dec_in   = 2'd3;
    dec_en   = 1'b1;
    @(posedge clk); #1;
    check_all("pre_reset", 2, 0, 2, 1, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_all("reset_held", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("release", 2, 0, 2, 1, 8);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 200; i++) begin
      int eo, ee, po, pv, dq;
      enc_in   = 4'($urandom_range(0, 15));
      p_enc_in = 4'($urandom_range(0, 15));
      dec_in   = 2'($urandom_range(0, 3));
      dec_en   = 1'($urandom_range(0, 1));
      model(int'(enc_in), int'(p_enc_in), int'(dec_in), dec_en, eo, ee, po, pv, dq);
      @(posedge clk); #1;
      check_all($sformatf("rand%0d", i), eo, ee, po, pv, dq);
    end

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
